// File: rtl/booth_product_accumulator.sv
// rtl/booth_product_accumulator.sv - frame accumulator for signed Booth products (option: BOOTH_ACC_SATURATE_EN)
module booth_product_accumulator #(
    parameter int PW = 8,
    parameter int AW = 16,
    parameter int CW = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clear,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic signed [PW-1:0] in_product,
    input  logic                 in_last,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic signed [AW-1:0] out_sum,
    output logic [CW-1:0]        out_count,
    output logic                 out_ovf
);

    typedef enum logic {ACCUM, HOLD} state_t;

    localparam logic signed [AW-1:0] ACC_MAX = {1'b0, {(AW-1){1'b1}}};
    localparam logic signed [AW-1:0] ACC_MIN = {1'b1, {(AW-1){1'b0}}};

    state_t               state;
    state_t               state_next;
    logic signed [AW-1:0] acc;
    logic signed [AW-1:0] acc_next;
    logic [CW-1:0]        count;
    logic [CW-1:0]        count_next;
    logic                 ovf;
    logic                 ovf_next;

    logic signed [AW-1:0] addend;
    logic signed [AW-1:0] sum_raw;
    logic signed [AW-1:0] sum_sel;
    logic                 add_ovf;

    assign addend  = AW'(in_product);
    assign sum_raw = acc + addend;
    // Same-sign operands producing a result of the opposite sign means the AW-bit sum left range.
    assign add_ovf = (acc[AW-1] == addend[AW-1]) && (sum_raw[AW-1] != acc[AW-1]);

`ifdef BOOTH_ACC_SATURATE_EN
    // Clamp toward the addend's sign; a later opposite-sign addend pulls the sum back in range.
    assign sum_sel = add_ovf ? (addend[AW-1] ? ACC_MIN : ACC_MAX) : sum_raw;
`else
    // Plain two's-complement wrap.
    assign sum_sel = sum_raw;
`endif

    assign out_sum   = acc;
    assign out_count = count;
    assign out_ovf   = ovf;

    // State and frame registers; the result registers double as the output holding stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ACCUM;
            acc   <= '0;
            count <= '0;
            ovf   <= 1'b0;
        end else begin
            state <= state_next;
            acc   <= acc_next;
            count <= count_next;
            ovf   <= ovf_next;
        end
    end

    // Next-state, accumulate/clear decisions and handshake outputs.
    always_comb begin
        state_next = state;
        acc_next   = acc;
        count_next = count;
        ovf_next   = ovf;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state)
            ACCUM: begin
                in_ready = !clear;
                if (clear) begin
                    acc_next   = '0;
                    count_next = '0;
                    ovf_next   = 1'b0;
                end else if (in_valid) begin
                    acc_next   = sum_sel;
                    count_next = (&count) ? count : count + CW'(1);
                    ovf_next   = ovf | add_ovf;
                    if (in_last) begin
                        state_next = HOLD;
                    end
                end
            end
            HOLD: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    acc_next   = '0;
                    count_next = '0;
                    ovf_next   = 1'b0;
                    state_next = ACCUM;
                end
            end
            default: begin
                state_next = ACCUM;
            end
        endcase
    end

endmodule
